// File: rtl/gps_pkg.sv
// Shared GPS L1 C/A constants: code length, PRN width, G1/G2 polynomials
// and the IS-GPS-200 G2 phase-tap table for PRN 1..32.
package gps_pkg;

  localparam int CA_CODE_LEN = 1023;
  localparam int PRN_W       = 6;
  localparam int NUM_PRN     = 32;

  // Bit k-1 set means x^k is a feedback term: G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10.
  localparam logic [9:0] G1_POLY = 10'h204;
  localparam logic [9:0] G2_POLY = 10'h3A6;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } tap_pair_t;

  localparam tap_pair_t G2_TAPS [NUM_PRN] = '{
    '{4'd2, 4'd6},  '{4'd3, 4'd7},  '{4'd4, 4'd8},  '{4'd5, 4'd9},
    '{4'd1, 4'd9},  '{4'd2, 4'd10}, '{4'd1, 4'd8},  '{4'd2, 4'd9},
    '{4'd3, 4'd10}, '{4'd2, 4'd3},  '{4'd3, 4'd4},  '{4'd5, 4'd6},
    '{4'd6, 4'd7},  '{4'd7, 4'd8},  '{4'd8, 4'd9},  '{4'd9, 4'd10},
    '{4'd1, 4'd4},  '{4'd2, 4'd5},  '{4'd3, 4'd6},  '{4'd4, 4'd7},
    '{4'd5, 4'd8},  '{4'd6, 4'd9},  '{4'd1, 4'd3},  '{4'd4, 4'd6},
    '{4'd5, 4'd7},  '{4'd6, 4'd8},  '{4'd7, 4'd9},  '{4'd8, 4'd10},
    '{4'd1, 4'd6},  '{4'd2, 4'd7},  '{4'd3, 4'd8},  '{4'd4, 4'd9}
  };

  function automatic logic prn_ok(input logic [PRN_W-1:0] prn);
    return (prn >= 6'd1) && (prn <= 6'd32);
  endfunction

  // prn_lo is the low five bits of a valid PRN; PRN 32 wraps to table entry 31.
  function automatic logic ca_chip(input logic [9:0] g1, input logic [9:0] g2,
                                   input logic [4:0] prn_lo);
    logic [4:0] idx;
    tap_pair_t  taps;
    logic [3:0] i1;
    logic [3:0] i2;
    idx  = prn_lo - 5'd1;
    taps = G2_TAPS[idx];
    i1   = taps.s1 - 4'd1;
    i2   = taps.s2 - 4'd1;
    return g1[9] ^ g2[i1] ^ g2[i2];
  endfunction

endpackage

// File: rtl/ca_lfsr10.sv
// One 10-stage Fibonacci LFSR; stage k lives in bit k-1 and feeds stage k+1.
// Exposes the state it will hold after this edge so the parent can register its output.
module ca_lfsr10 #(
  parameter logic [9:0] POLY = 10'h204
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load_ones,
  input  logic       i_step,
  output logic [9:0] o_next_state
);

  logic [9:0] r_state;
  logic       w_feedback;

  // NOTE: defaults first so every path assigns every output -- no latch is inferred.
  always_comb begin
    w_feedback   = ^(r_state & POLY);
    o_next_state = r_state;
    if (i_load_ones)  o_next_state = '1;
    else if (i_step)  o_next_state = {r_state[8:0], w_feedback};
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= '1;
    else     r_state <= o_next_state;
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator with registered outputs.
// Define CA_CODE_NCO_EN to advance chips from a code NCO carry instead of chip_en.
module ca_code_gen
  import gps_pkg::*;
#(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PRN_W-1:0] prn_sel,
  input  logic             prn_load,
`ifdef CA_CODE_NCO_EN
  input  logic [NCO_W-1:0] code_fcw,
`else
  input  logic             chip_en,
`endif
  output logic             code_out,
  output logic             chip_strobe,
  output logic             epoch,
  output logic [9:0]       chip_idx,
  output logic             prn_valid
);

  if (NCO_W < 2) begin : g_bad_nco_w
    $error("NCO_W must be at least 2");
  end

  logic             w_adv;
  logic             w_wrap;
  logic             w_load_ones;
  logic             w_step;
  logic [9:0]       w_g1_next;
  logic [9:0]       w_g2_next;
  logic [PRN_W-1:0] w_prn_next;

  logic [PRN_W-1:0] r_prn;
  logic [9:0]       r_chip_idx;
  logic             r_code_out;
  logic             r_chip_strobe;
  logic             r_epoch;
  logic             r_prn_valid;

`ifdef CA_CODE_NCO_EN
  logic [NCO_W-1:0] r_acc;
  logic [NCO_W-1:0] w_acc_sum;
  logic             w_carry;

  assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, code_fcw};
  assign w_adv                = w_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_acc <= '0;
    else if (prn_load) r_acc <= '0;
    else               r_acc <= w_acc_sum;
  end
`else
  assign w_adv = chip_en;
`endif

  // A load wins over a same-cycle advance; the last chip of a period reloads all ones.
  assign w_wrap      = w_adv && (r_chip_idx == 10'(CA_CODE_LEN - 1));
  assign w_load_ones = prn_load | w_wrap;
  assign w_step      = w_adv & ~prn_load;
  assign w_prn_next  = prn_load ? prn_sel : r_prn;

  ca_lfsr10 #(.POLY(G1_POLY)) u_g1 (
    .clk          (clk),
    .rst          (rst),
    .i_load_ones  (w_load_ones),
    .i_step       (w_step),
    .o_next_state (w_g1_next)
  );

  ca_lfsr10 #(.POLY(G2_POLY)) u_g2 (
    .clk          (clk),
    .rst          (rst),
    .i_load_ones  (w_load_ones),
    .i_step       (w_step),
    .o_next_state (w_g2_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prn         <= 6'd1;
      r_prn_valid   <= 1'b1;
      r_chip_idx    <= '0;
      r_code_out    <= 1'b1;
      r_epoch       <= 1'b0;
      r_chip_strobe <= 1'b0;
    end else begin
      r_prn       <= w_prn_next;
      r_prn_valid <= prn_ok(w_prn_next);
      r_code_out  <= prn_ok(w_prn_next) & ca_chip(w_g1_next, w_g2_next, w_prn_next[4:0]);
      if (prn_load) begin
        r_chip_idx    <= '0;
        r_epoch       <= 1'b0;
        r_chip_strobe <= 1'b0;
      end else if (w_adv) begin
        r_chip_idx    <= w_wrap ? 10'd0 : r_chip_idx + 10'd1;
        r_epoch       <= w_wrap;
        r_chip_strobe <= 1'b1;
      end else begin
        r_epoch       <= 1'b0;
        r_chip_strobe <= 1'b0;
      end
    end
  end

  assign code_out    = r_code_out;
  assign chip_strobe = r_chip_strobe;
  assign epoch       = r_epoch;
  assign chip_idx    = r_chip_idx;
  assign prn_valid   = r_prn_valid;

endmodule

// File: tb/tb_ca_code_gen.sv
// Self-checking bench for ca_code_gen: a sequence-level reference model (code tables built
// from the G1/G2 recurrences, chip index as modular arithmetic) checked every cycle, plus literal checks.
module tb_ca_code_gen;

  localparam int NCO_W = 32;
  localparam int LEN   = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] prn_sel = 6'd0;
  logic       prn_load = 1'b0;
`ifdef CA_CODE_NCO_EN
  logic [NCO_W-1:0] code_fcw = '0;
`else
  logic       chip_en = 1'b0;
`endif
  logic       code_out;
  logic       chip_strobe;
  logic       epoch;
  logic [9:0] chip_idx;
  logic       prn_valid;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  ca_code_gen #(.NCO_W(NCO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .prn_sel     (prn_sel),
    .prn_load    (prn_load),
`ifdef CA_CODE_NCO_EN
    .code_fcw    (code_fcw),
`else
    .chip_en     (chip_en),
`endif
    .code_out    (code_out),
    .chip_strobe (chip_strobe),
    .epoch       (epoch),
    .chip_idx    (chip_idx),
    .prn_valid   (prn_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Code tables: x[t] = x[t-3]^x[t-10] (G1), y[t] = y[t-2]^y[t-3]^y[t-6]^y[t-8]^y[t-9]^y[t-10] (G2),
  // chip(t) = x[t-10] ^ y[t-s1] ^ y[t-s2], with x and y equal to 1 for t < 0 (index offset 10).
  bit tbl [33][LEN];

  function automatic void build_tables();
    int s1 [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int s2 [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    bit xs [LEN+10];
    bit ys [LEN+10];
    for (int i = 0; i < 10; i++) begin
      xs[i] = 1'b1;
      ys[i] = 1'b1;
    end
    for (int t = 0; t < LEN; t++) begin
      xs[t+10] = xs[t+7] ^ xs[t];
      ys[t+10] = ys[t+8] ^ ys[t+7] ^ ys[t+4] ^ ys[t+2] ^ ys[t+1] ^ ys[t];
    end
    for (int p = 1; p <= 32; p++)
      for (int t = 0; t < LEN; t++)
        tbl[p][t] = xs[t] ^ ys[t+10-s1[p-1]] ^ ys[t+10-s2[p-1]];
  endfunction

  function automatic logic [9:0] first10(input int p);
    logic [9:0] v = '0;
    for (int t = 0; t < 10; t++) v = {v[8:0], tbl[p][t]};
    return v;
  endfunction

  // Reference model: latched PRN, chip index, pulse flags.
  int m_prn = 1;
  int m_idx = 0;
  bit m_epoch = 1'b0;
  bit m_strobe = 1'b0;
`ifdef CA_CODE_NCO_EN
  longint unsigned m_acc = 0;
`endif

  always @(posedge clk or posedge rst) begin : ref_model
    bit adv;
    if (rst) begin
      m_prn = 1; m_idx = 0; m_epoch = 1'b0; m_strobe = 1'b0;
`ifdef CA_CODE_NCO_EN
      m_acc = 0;
`endif
    end else begin
`ifdef CA_CODE_NCO_EN
      m_acc = m_acc + code_fcw;
      adv   = (m_acc >= (64'd1 << NCO_W));
      m_acc = m_acc % (64'd1 << NCO_W);
`else
      adv = chip_en;
`endif
      if (prn_load) begin
        m_prn = int'(prn_sel); m_idx = 0; m_epoch = 1'b0; m_strobe = 1'b0;
`ifdef CA_CODE_NCO_EN
        m_acc = 0;
`endif
      end else if (adv) begin
        m_idx    = (m_idx + 1) % LEN;
        m_epoch  = (m_idx == 0);
        m_strobe = 1'b1;
      end else begin
        m_epoch = 1'b0; m_strobe = 1'b0;
      end
    end
  end

  function automatic bit m_valid();
    return (m_prn >= 1) && (m_prn <= 32);
  endfunction

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("code_out",    32'(code_out),    32'(m_valid() ? tbl[m_prn][m_idx] : 1'b0));
      check("chip_idx",    32'(chip_idx),    32'(m_idx));
      check("epoch",       32'(epoch),       32'(m_epoch));
      check("chip_strobe", 32'(chip_strobe), 32'(m_strobe));
      check("prn_valid",   32'(prn_valid),   32'(m_valid()));
    end
  end

  task automatic reset_literals(input string tag);
    check({tag, "_code_out"},    32'(code_out),    32'd1);
    check({tag, "_chip_idx"},    32'(chip_idx),    32'd0);
    check({tag, "_prn_valid"},   32'(prn_valid),   32'd1);
    check({tag, "_epoch"},       32'(epoch),       32'd0);
    check({tag, "_chip_strobe"}, 32'(chip_strobe), 32'd0);
  endtask

  task automatic midrun_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_literals("midrst");
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifndef CA_CODE_NCO_EN
  task automatic load_prn(input logic [5:0] p);
    @(negedge clk);
    chip_en = 1'b0; prn_load = 1'b1; prn_sel = p;
  endtask

  task automatic collect10(output logic [9:0] seq);
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq = {seq[8:0], code_out};
      chip_en = 1'b1; prn_load = 1'b0;
    end
    @(negedge clk);
    chip_en = 1'b0;
  endtask

  // Samples n+1 chips while applying n advances.
  task automatic run_span(input int n, output int ep, output int ep_at, output int ep_code,
                          output int ep_idx, output int ones, output int valids);
    ep = 0; ep_at = -1; ep_code = -1; ep_idx = -1; ones = 0; valids = 0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (epoch) begin
        ep++; ep_at = i; ep_code = int'(code_out); ep_idx = int'(chip_idx);
      end
      ones   += int'(code_out);
      valids += int'(prn_valid);
      chip_en  = (i < n);
      prn_load = 1'b0;
    end
  endtask

  task automatic rand_run(input int n, input int en_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chip_en  = ($urandom_range(0, 99) < en_pct);
      prn_load = ($urandom_range(0, 999) == 0);
      prn_sel  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'($urandom_range(1, 32));
    end
    @(negedge clk);
    chip_en = 1'b0; prn_load = 1'b0;
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [9:0] seq;
    int ep, ep_at, ep_code, ep_idx, ones, valids;
    build_tables();
    check("model_prn1_first10", 32'(first10(1)), 32'h320);
    check("model_prn2_first10", 32'(first10(2)), 32'h390);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
`ifdef CA_CODE_NCO_EN
    code_fcw = 32'h4000_0000;
`endif
    rst = 1'b0;
    chk_on = 1'b1;
    reset_literals("rst");

`ifndef CA_CODE_NCO_EN
    collect10(seq);
    check("prn1_first10", 32'(seq), 32'h320);
    load_prn(6'd2);
    collect10(seq);
    check("prn2_first10", 32'(seq), 32'h390);

    load_prn(6'd1);
    run_span(LEN, ep, ep_at, ep_code, ep_idx, ones, valids);
    check("period_epoch_count", 32'(ep), 32'd1);
    check("period_epoch_at",    32'(ep_at), 32'd1023);
    check("period_epoch_idx",   32'(ep_idx), 32'd0);
    check("period_epoch_code",  32'(ep_code), 32'd1);
    collect10(seq);
    check("after_wrap_first10", 32'(seq), 32'h320);

    load_prn(6'd5);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      chip_en = 1'b1; prn_load = 1'b0;
    end
    @(negedge clk);
    check("pre_collide_idx", 32'(chip_idx), 32'd500);
    chip_en = 1'b1; prn_load = 1'b1; prn_sel = 6'd7;
    @(negedge clk);
    check("collide_idx",    32'(chip_idx), 32'd0);
    check("collide_epoch",  32'(epoch), 32'd0);
    check("collide_strobe", 32'(chip_strobe), 32'd0);
    chip_en = 1'b0; prn_load = 1'b0;

    load_prn(6'd0);
    run_span(2 * LEN, ep, ep_at, ep_code, ep_idx, ones, valids);
    check("prn0_epochs",    32'(ep), 32'd2);
    check("prn0_ones",      32'(ones), 32'd0);
    check("prn0_valid_cnt", 32'(valids), 32'd0);

    load_prn(6'd40);
    rand_run(300, 60);
    load_prn(6'd17);
    rand_run(2500, 85);
    rand_run(300, 20);
    midrun_reset();
    rand_run(400, 70);
`else
    begin
      int prev = -1, bad = 0, n = 0, ep_first = -1, ep_gap = -1;
      ep = 0;
      for (int c = 0; c < 8300; c++) begin
        @(negedge clk);
        if (chip_strobe) begin
          if (prev >= 0 && c - prev != 4) bad++;
          prev = c; n++;
        end
        if (epoch) begin
          if (ep_first < 0) ep_first = c;
          else if (ep_gap < 0) ep_gap = c - ep_first;
          ep++;
        end
      end
      check("nco_strobe_gap_errors", 32'(bad), 32'd0);
      check("nco_strobe_count",      32'(n), 32'd2075);
      check("nco_epoch_count",       32'(ep), 32'd2);
      check("nco_epoch_first",       32'(ep_first), 32'd4091);
      check("nco_epoch_gap",         32'(ep_gap), 32'd4092);
    end
    midrun_reset();
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) code_fcw = $urandom;
      prn_load = ($urandom_range(0, 499) == 0);
      prn_sel  = 6'($urandom_range(0, 40));
    end
    @(negedge clk);
    prn_load = 1'b0;
    midrun_reset();
    repeat (50) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
